// File: rtl/ceyloniac_multi_cycle_ctrl_unit_if.sv
// Control bus between the CEYLONIAC multi-cycle datapath (master) and its control unit (slave).
// The datapath supplies opcode/overflow/enable; the control unit returns selects, enables and debug state.
interface ceyloniac_multi_cycle_ctrl_unit_if;
  logic [5:0] opcode;
  logic       overflow;
  logic       control_enable;
  logic [3:0] alu_op;
  logic       pc_write_cond;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       ir_write;
  logic       alu_src_a;
  logic       reg_write;
  logic       reg_dst;
  logic       epc_write;
  logic       cause_write;
  logic [1:0] pc_source;
  logic [1:0] alu_src_b;
  logic       int_cause;
  logic [3:0] current_state;

  modport master (
    output opcode, overflow, control_enable,
    input  alu_op, pc_write_cond, pc_write, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
    input  alu_src_a, reg_write, reg_dst, epc_write, cause_write, pc_source, alu_src_b,
    input  int_cause, current_state
  );

  modport slave (
    input  opcode, overflow, control_enable,
    output alu_op, pc_write_cond, pc_write, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
    output alu_src_a, reg_write, reg_dst, epc_write, cause_write, pc_source, alu_src_b,
    output int_cause, current_state
  );
endinterface

// File: rtl/ceyloniac_multi_cycle_ctrl_unit.sv
// Moore control FSM for the CEYLONIAC multi-cycle datapath: sequences each instruction through
// fetch/decode/execute/memory/writeback and raises the EPC/Cause exception path.
module ceyloniac_multi_cycle_ctrl_unit (
  input  logic                              clk,
  input  logic                              reset,
  ceyloniac_multi_cycle_ctrl_unit_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b010001;
  localparam logic [5:0] OP_STORE = 6'b010010;
  localparam logic [5:0] OP_WBIT  = 6'b010101;
  localparam logic [5:0] OP_BREQ  = 6'b011001;
  localparam logic [5:0] OP_JMP   = 6'b011100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_EXC      = 4'd12
  } state_e;

  state_e state_q, state_d;
  logic   cause_q, cause_d;
  // Opcode is only looked at in DECODE, so remember load-vs-store for the MEM_ADDR branch.
  logic   is_load_q, is_load_d;

  logic [3:0] alu_op_s;
  logic       pc_write_cond_s, pc_write_s, i_or_d_s, mem_read_s, mem_write_s, mem_to_reg_s;
  logic       ir_write_s, alu_src_a_s, reg_write_s, reg_dst_s, epc_write_s, cause_write_s;
  logic [1:0] pc_source_s, alu_src_b_s;
  logic       int_cause_s;
  logic       out_en_s;

  // State, cause and load-flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cause_q   <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      is_load_q <= is_load_d;
    end
  end

  // Next-state logic; a deasserted enable freezes everything
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    is_load_d = is_load_q;
    if (bus.control_enable) begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          is_load_d = (bus.opcode == OP_LOAD);
          case (bus.opcode)
            OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
            OP_RTYPE:          state_d = S_EXEC;
            OP_BREQ:           state_d = S_BRANCH;
            OP_JMP:            state_d = S_JUMP;
            OP_WBIT:           state_d = S_IMM_EXEC;
            default: begin
              state_d = S_EXC;
              cause_d = 1'b0;
            end
          endcase
        end
        S_MEM_ADDR: state_d = is_load_q ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   state_d = S_MEM_WB;
        S_EXEC, S_IMM_EXEC: begin
          if (bus.overflow) begin
            state_d = S_EXC;
            cause_d = 1'b1;
          end else begin
            state_d = (state_q == S_EXEC) ? S_R_WB : S_IMM_WB;
          end
        end
        S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB, S_EXC: state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Moore output decode from the state register (ungated)
  always_comb begin
    alu_op_s        = 4'b0000;
    pc_write_cond_s = 1'b0;
    pc_write_s      = 1'b0;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    mem_to_reg_s    = 1'b0;
    ir_write_s      = 1'b0;
    alu_src_a_s     = 1'b0;
    reg_write_s     = 1'b0;
    reg_dst_s       = 1'b0;
    epc_write_s     = 1'b0;
    cause_write_s   = 1'b0;
    pc_source_s     = 2'b00;
    alu_src_b_s     = 2'b00;
    int_cause_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        ir_write_s  = 1'b1;
        pc_write_s  = 1'b1;
        alu_src_b_s = 2'b01;
      end
      S_DECODE: alu_src_b_s = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 4'b0010;
      end
      S_R_WB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 4'b0001;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
      end
      S_JUMP: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'b10;
      end
      S_IMM_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_op_s    = 4'b0011;
      end
      S_IMM_WB: reg_write_s = 1'b1;
      S_EXC: begin
        // ALU computes PC-4 so EPC holds the faulting instruction's address
        epc_write_s   = 1'b1;
        cause_write_s = 1'b1;
        pc_write_s    = 1'b1;
        pc_source_s   = 2'b11;
        alu_src_b_s   = 2'b01;
        alu_op_s      = 4'b0001;
        int_cause_s   = cause_q;
      end
      default: alu_op_s = 4'b0000;
    endcase
  end

  // Outputs are forced low while in reset as well as while disabled
  assign out_en_s = bus.control_enable & reset;

  assign bus.alu_op        = out_en_s ? alu_op_s    : 4'b0000;
  assign bus.pc_source     = out_en_s ? pc_source_s : 2'b00;
  assign bus.alu_src_b     = out_en_s ? alu_src_b_s : 2'b00;
  assign bus.pc_write_cond = out_en_s & pc_write_cond_s;
  assign bus.pc_write      = out_en_s & pc_write_s;
  assign bus.i_or_d        = out_en_s & i_or_d_s;
  assign bus.mem_read      = out_en_s & mem_read_s;
  assign bus.mem_write     = out_en_s & mem_write_s;
  assign bus.mem_to_reg    = out_en_s & mem_to_reg_s;
  assign bus.ir_write      = out_en_s & ir_write_s;
  assign bus.alu_src_a     = out_en_s & alu_src_a_s;
  assign bus.reg_write     = out_en_s & reg_write_s;
  assign bus.reg_dst       = out_en_s & reg_dst_s;
  assign bus.epc_write     = out_en_s & epc_write_s;
  assign bus.cause_write   = out_en_s & cause_write_s;
  assign bus.int_cause     = out_en_s & int_cause_s;
  assign bus.current_state = state_q;

endmodule

// File: tb/tb_ceyloniac_multi_cycle_ctrl_unit.sv
// Self-checking bench: directed state-path table, enable-freeze and mid-instruction reset sequences,
// then random instructions checked against a rule-level path/output model.
module tb_ceyloniac_multi_cycle_ctrl_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  ceyloniac_multi_cycle_ctrl_unit_if bus ();

  ceyloniac_multi_cycle_ctrl_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] opc;
    bit         ovf;
    int         n;
    int         st[6];
  } vec_t;

  vec_t tbl[9];

  function automatic logic [20:0] act_out();
    return {bus.alu_op, bus.pc_write_cond, bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.mem_to_reg, bus.ir_write, bus.alu_src_a, bus.reg_write, bus.reg_dst, bus.epc_write,
            bus.cause_write, bus.pc_source, bus.alu_src_b, bus.int_cause};
  endfunction

  // Expected control word for a state, straight from the per-state output list
  function automatic logic [20:0] exp_out(input int st, input bit c);
    logic [3:0] op = 4'b0000;
    logic pwc = 1'b0, pw = 1'b0, iord = 1'b0, mr = 1'b0, mw = 1'b0, m2r = 1'b0, irw = 1'b0;
    logic sa = 1'b0, rw = 1'b0, rd = 1'b0, ew = 1'b0, cw = 1'b0, ic = 1'b0;
    logic [1:0] ps = 2'b00, sb = 2'b00;
    case (st)
      0:  begin mr = 1'b1; irw = 1'b1; pw = 1'b1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin mr = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; iord = 1'b1; end
      6:  begin sa = 1'b1; op = 4'b0010; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin sa = 1'b1; op = 4'b0001; pwc = 1'b1; ps = 2'b01; end
      9:  begin pw = 1'b1; ps = 2'b10; end
      10: begin sa = 1'b1; sb = 2'b10; op = 4'b0011; end
      11: rw = 1'b1;
      12: begin ew = 1'b1; cw = 1'b1; pw = 1'b1; ps = 2'b11; sb = 2'b01; op = 4'b0001; ic = c; end
      default: op = 4'b0000;
    endcase
    return {op, pwc, pw, iord, mr, mw, m2r, irw, sa, rw, rd, ew, cw, ps, sb, ic};
  endfunction

  // Reference: the sequence of states an instruction visits, from the opcode rules
  function automatic void ref_path(input logic [5:0] opc, input bit ovf, output int p[6], output int n);
    p = '{0, 1, 0, 0, 0, 0};
    case (opc)
      6'b010001: begin p[2] = 2;  p[3] = 3;  p[4] = 4; n = 5; end
      6'b010010: begin p[2] = 2;  p[3] = 5;  n = 4; end
      6'b000000: begin p[2] = 6;  p[3] = ovf ? 12 : 7;  n = 4; end
      6'b010101: begin p[2] = 10; p[3] = ovf ? 12 : 11; n = 4; end
      6'b011001: begin p[2] = 8;  n = 3; end
      6'b011100: begin p[2] = 9;  n = 3; end
      default:   begin p[2] = 12; n = 3; end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk one instruction from FETCH; opcode/overflow are noise outside the states that sample them
  task automatic run_instr(input logic [5:0] opc, input bit ovf, input int p[6], input int n);
    bit c;
    for (int k = 0; k < n; k++) begin
      bus.opcode   = (p[k] == 1) ? opc : 6'($urandom);
      bus.overflow = (p[k] == 6 || p[k] == 10) ? ovf : 1'($urandom);
      c = (p[k] == 12) && (k > 0) && (p[k-1] == 6 || p[k-1] == 10);
      chk($sformatf("state op=%b k=%0d", opc, k), 32'(bus.current_state), 32'(p[k]));
      chk($sformatf("outs st=%0d", p[k]), 32'(act_out()), 32'(exp_out(p[k], c)));
      tick();
    end
  endtask

  initial begin
    int p[6];
    int n;
    logic [5:0] opc;
    bit ovf;
    logic [5:0] pool[6];

    tbl[0] = '{6'b010001, 1'b0, 5, '{0, 1, 2, 3, 4, 0}};
    tbl[1] = '{6'b010010, 1'b0, 4, '{0, 1, 2, 5, 0, 0}};
    tbl[2] = '{6'b000000, 1'b0, 4, '{0, 1, 6, 7, 0, 0}};
    tbl[3] = '{6'b000000, 1'b1, 4, '{0, 1, 6, 12, 0, 0}};
    tbl[4] = '{6'b011001, 1'b0, 3, '{0, 1, 8, 0, 0, 0}};
    tbl[5] = '{6'b011100, 1'b0, 3, '{0, 1, 9, 0, 0, 0}};
    tbl[6] = '{6'b010101, 1'b0, 4, '{0, 1, 10, 11, 0, 0}};
    tbl[7] = '{6'b010101, 1'b1, 4, '{0, 1, 10, 12, 0, 0}};
    tbl[8] = '{6'b111111, 1'b0, 3, '{0, 1, 12, 0, 0, 0}};
    pool = '{6'b000000, 6'b010001, 6'b010010, 6'b010101, 6'b011001, 6'b011100};

    reset = 1'b0;
    bus.control_enable = 1'b1;
    bus.opcode = 6'b000000;
    bus.overflow = 1'b0;
    #2;
    chk("reset state", 32'(bus.current_state), 32'd0);
    chk("reset outs", 32'(act_out()), 32'd0);
    tick();
    reset = 1'b1;
    #1;

    for (int i = 0; i < 9; i++) run_instr(tbl[i].opc, tbl[i].ovf, tbl[i].st, tbl[i].n);

    // Freeze in MEM_RD for three clocks, then resume into MEM_WB
    bus.opcode = 6'b010001;
    tick(); tick(); tick();
    chk("pre-freeze state", 32'(bus.current_state), 32'd3);
    bus.control_enable = 1'b0;
    #1;
    chk("freeze outs", 32'(act_out()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("freeze state", 32'(bus.current_state), 32'd3);
      chk("freeze outs hold", 32'(act_out()), 32'd0);
    end
    bus.control_enable = 1'b1;
    #1;
    chk("resume outs", 32'(act_out()), 32'(exp_out(3, 1'b0)));
    tick();
    chk("resume state", 32'(bus.current_state), 32'd4);
    tick();
    chk("back to fetch", 32'(bus.current_state), 32'd0);

    // Async reset in the middle of an R-type EXEC
    bus.opcode = 6'b000000;
    bus.overflow = 1'b0;
    tick(); tick();
    chk("exec state", 32'(bus.current_state), 32'd6);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset state", 32'(bus.current_state), 32'd0);
    chk("async reset outs", 32'(act_out()), 32'd0);
    tick();
    chk("reset held state", 32'(bus.current_state), 32'd0);
    reset = 1'b1;
    #1;
    chk("release fetch outs", 32'(act_out()), 32'(exp_out(0, 1'b0)));
    ref_path(6'b011100, 1'b0, p, n);
    run_instr(6'b011100, 1'b0, p, n);

    // Random instruction stream against the path model
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) opc = 6'($urandom);
      else opc = pool[$urandom_range(0, 5)];
      ovf = 1'($urandom);
      ref_path(opc, ovf, p, n);
      run_instr(opc, ovf, p, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
